puf_race_counter: RTL and testbench
===================================

Name: puf_race_counter

Overview:
- Multi-channel race arbiter/counter for the delay-based PUF response path.
- Each of NCH channels counts the clock cycles in which its increment qualifier is high.
- The first channel whose count reaches a programmable goal wins the race. Its index, tie/timeout flags and all channel counts are frozen for readout.
- Successor to the single-channel goal counter: adds run-time goal, N channels, start/done handshake, winner/tie detection, timeout and restart without reset.

Parameters:
- N, 23, width of each channel counter and of the goal.
- NCH, 2, number of racing channels (NCH >= 2).
- IDX_W, 1, width of the winner index; must be >= clog2(NCH).
- TMO_W, 24, width of the race-duration cycle counter; timeout fires at all-ones.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a new race; honoured in IDLE and DONE, ignored in RUN
- goal  input  N  count value that ends the race; sampled only on the accepted start edge
- inc  input  NCH  per-channel increment qualifier, bit i drives channel i
- busy  output  1  high while state == RUN
- done  output  1  one-cycle pulse on entry to DONE
- valid  output  1  high in DONE (results stable); low in IDLE/RUN
- winner  output  IDX_W  lowest-index channel whose count == goal; 0 on timeout
- tie  output  1  more than one channel == goal at decision edge
- timeout  output  1  race ended by cycle counter, no channel hit goal
- counts  output  NCH*N  channel counts, channel i at bits [i*N +: N]

Behaviour:
- Reset is synchronous and active-high, with priority over everything.
  - Reset values: state=IDLE, all counts=0, cycle counter=0, goal_q=0, busy=0, done=0, valid=0, winner=0, tie=0, timeout=0.
  - Reset asserted mid-RUN aborts the race; no done pulse is produced.
- States: IDLE, RUN, DONE (2-bit encoded).
- IDLE/DONE with start=1:
  - Next state RUN.
  - counts<=0, cyc<=0, goal_q<=goal.
  - winner/tie/timeout<=0, valid<=0.
- IDLE/DONE with start=0: hold all state; DONE keeps results and valid=1 indefinitely.
- RUN, evaluated each edge in this priority order:
  - 1) hit = any count_i == goal_q (registered compare). If hit:
    - next DONE, done<=1, valid<=1.
    - winner<=lowest i with hit; tie<=(number of hits >= 2).
    - counts are not incremented on this edge.
  - 2) else if cyc == all-ones: next DONE, done<=1, valid<=1, timeout<=1, winner<=0, tie<=0.
  - 3) else count_i<=count_i+inc[i] for every i, and cyc<=cyc+1.
- Latency: with start accepted at edge 0 and inc[i] held high from edge 1, count_i==G after edge G; done is high in the cycle after edge G+1.
- No count can exceed goal_q, because the race freezes on equality, so no wrap is possible.
  - goal==0 is legal: hit on the first RUN edge, all channels tie, winner=0, tie=1.
- A hit on the same edge the cycle counter is all-ones: the hit wins and timeout=0.
- done is exactly one cycle wide. It is cleared on the next edge regardless of start.
- start held high continuously in DONE starts a new race on the first DONE edge. In that case done is visible for one cycle and valid for one cycle.
- goal changes during RUN have no effect (goal_q is used).
- inc is assumed synchronous to clk; no synchronisers are inside this block.

Test Plan:
- Reset mid-race:
  - Stimulus: reset=1 for 2 cycles during RUN.
  - Required: all outputs 0, state IDLE.
  - Then start with goal=5, inc=2'b01 held: done pulses 1 cycle after edge 6; winner=0, tie=0, counts={0,5}, valid stays 1.
- Winner and freeze:
  - Stimulus: goal=8; inc[1]=1 every cycle, inc[0]=1 every other cycle.
  - Required: winner=1, tie=0, counts ch1=8 and ch0=4; counts remain frozen while start=0.
- Tie:
  - Stimulus: goal=3, inc=2'b11 from first RUN edge.
  - Required: winner=0, tie=1, both counts=3.
  - goal=0: done after first RUN edge, tie=1, counts=0.
- Timeout (TMO_W=4 build):
  - Stimulus: goal=100, inc=0.
  - Required: done after 16 RUN edges, timeout=1, winner=0.
  - Hit coinciding with cyc=15 gives timeout=0.
- Handshake:
  - start asserted during RUN is ignored (race unaffected).
  - start held high through DONE restarts immediately: done is 1 cycle, counts cleared, goal re-sampled.
  - goal changed mid-RUN is not used.

Source files
------------

// File: rtl/puf_race_counter.sv
// Multi-channel PUF race counter: first channel to reach the goal wins,
// with tie detection, timeout and frozen result readout.
module puf_race_counter #(
  parameter int N     = 23,
  parameter int NCH   = 2,
  parameter int IDX_W = 1,
  parameter int TMO_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     goal,
  input  logic [NCH-1:0]   inc,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [IDX_W-1:0] winner,
  output logic             tie,
  output logic             timeout,
  output logic [NCH*N-1:0] counts
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     cnt_q [NCH];
  logic [N-1:0]     cnt_d [NCH];
  logic [TMO_W-1:0] cyc_q, cyc_d;
  logic [N-1:0]     goal_q, goal_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic             tie_q, tie_d;
  logic             timeout_q, timeout_d;

  logic             hit_any;
  logic             hit_tie;
  logic [IDX_W-1:0] hit_idx;

  // Ascending scan: the first hit sets the winner, any later hit is a tie.
  always_comb begin
    hit_any = 1'b0;
    hit_tie = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_q[i] == goal_q) begin
        if (hit_any) hit_tie = 1'b1;
        else         hit_idx = IDX_W'(i);
        hit_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    goal_d    = goal_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    winner_d  = winner_q;
    tie_d     = tie_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          for (int i = 0; i < NCH; i++) cnt_d[i] = '0;
          cyc_d     = '0;
          goal_d    = goal;
          valid_d   = 1'b0;
          winner_d  = '0;
          tie_d     = 1'b0;
          timeout_d = 1'b0;
        end
      end
      RUN: begin
        if (hit_any) begin
          state_d  = DONE;
          done_d   = 1'b1;
          valid_d  = 1'b1;
          winner_d = hit_idx;
          tie_d    = hit_tie;
        end else if (&cyc_q) begin
          state_d   = DONE;
          done_d    = 1'b1;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          winner_d  = '0;
          tie_d     = 1'b0;
        end else begin
          for (int i = 0; i < NCH; i++)
            cnt_d[i] = cnt_q[i] + N'(inc[i]);
          cyc_d = cyc_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      cyc_q     <= '0;
      goal_q    <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      winner_q  <= '0;
      tie_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      goal_q    <= goal_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      winner_q  <= winner_d;
      tie_q     <= tie_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    counts = '0;
    for (int i = 0; i < NCH; i++)
      counts[i*N +: N] = cnt_q[i];
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign valid   = valid_q;
  assign winner  = winner_q;
  assign tie     = tie_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_puf_race_counter.sv
// Scoreboard bench for puf_race_counter (NCH=2, N=23, TMO_W=4):
// stimulus queues expected race results, a monitor checks each done.
module tb_puf_race_counter;

  localparam int N     = 23;
  localparam int NCH   = 2;
  localparam int IDX_W = 1;
  localparam int TMO_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [N-1:0]     goal;
  logic [NCH-1:0]   inc;
  logic             busy;
  logic             done;
  logic             valid;
  logic [IDX_W-1:0] winner;
  logic             tie;
  logic             timeout;
  logic [NCH*N-1:0] counts;

  typedef struct {
    logic [IDX_W-1:0] w;
    logic             t;
    logic             to;
    logic [NCH*N-1:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;

  puf_race_counter #(
    .N(N), .NCH(NCH), .IDX_W(IDX_W), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .goal(goal),
    .inc(inc), .busy(busy), .done(done), .valid(valid),
    .winner(winner), .tie(tie), .timeout(timeout),
    .counts(counts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic logic [NCH*N-1:0] pk(input int c1, input int c0);
    return {N'(c1), N'(c0)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic t, input logic to,
                      input logic [NCH*N-1:0] c);
    exp_t e;
    e.w  = w;
    e.t  = t;
    e.to = to;
    e.c  = c;
    exp_q.push_back(e);
  endtask

  task automatic start_race(input int g);
    start = 1'b1;
    goal  = N'(g);
    inc   = '0;
    tick();
    start = 1'b0;
  endtask

  // Hold inc and tick until done; the tick count is the decision latency.
  task automatic run(input logic [NCH-1:0] iv, input int lat,
                     input string nm);
    int n;
    inc = iv;
    n   = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
    chk(nm, 64'(n), 64'(lat));
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      chk("done_width", 64'(prev_done), 64'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 want no result");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", {15'd0, valid, winner, tie, timeout, counts},
            {15'd0, 1'b1, e.w, e.t, e.to, e.c});
      end
    end
    prev_done <= done;
  end

  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    goal  = '0;
    inc   = '0;
    tick();
    tick();
    chk("reset_state",
        {13'd0, busy, done, valid, winner, tie, timeout, counts},
        64'd0);
    reset = 1'b0;
    tick();

    // Abort a race in flight with a two-cycle reset.
    start_race(5);
    inc = 2'b11;
    tick();
    tick();
    chk("mid_run_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("mid_reset_state",
        {13'd0, busy, done, valid, winner, tie, timeout, counts},
        64'd0);

    push(1'b0, 1'b0, 1'b0, pk(0, 5));
    start_race(5);
    run(2'b01, 6, "lat_goal5");
    repeat (3) tick();
    chk("valid_hold", {61'd0, valid, done, busy}, 64'd4);
    chk("counts_hold", 64'(counts), 64'(pk(0, 5)));

    // ch1 every cycle, ch0 on odd edges only.
    push(1'b1, 1'b0, 1'b0, pk(8, 4));
    start_race(8);
    k = 0;
    do begin
      k++;
      inc = {1'b1, k[0]};
      tick();
    end while (!done && k < 40);
    chk("lat_goal8", 64'(k), 64'd9);
    inc = 2'b11;
    repeat (3) tick();
    chk("freeze", 64'(counts), 64'(pk(8, 4)));

    push(1'b0, 1'b1, 1'b0, pk(3, 3));
    start_race(3);
    run(2'b11, 4, "lat_tie3");

    push(1'b0, 1'b1, 1'b0, pk(0, 0));
    start_race(0);
    run(2'b11, 1, "lat_goal0");

    push(1'b0, 1'b0, 1'b1, pk(0, 0));
    start_race(100);
    run(2'b00, 16, "lat_timeout");

    // Hit on the same edge the cycle counter is all-ones.
    push(1'b0, 1'b0, 1'b0, pk(0, 15));
    start_race(15);
    run(2'b01, 16, "lat_hit_at_tmo");

    // start and goal changes during RUN must not disturb the race.
    push(1'b1, 1'b0, 1'b0, pk(4, 0));
    start_race(4);
    k = 0;
    do begin
      k++;
      inc   = 2'b10;
      start = (k == 2 || k == 3);
      goal  = (k >= 2) ? N'(1) : N'(4);
      tick();
    end while (!done && k < 40);
    chk("lat_ignore_start", 64'(k), 64'd5);

    // Restart straight from DONE with start held over the done cycle.
    start = 1'b1;
    goal  = N'(2);
    inc   = 2'b01;
    push(1'b0, 1'b0, 1'b0, pk(0, 2));
    tick();
    start = 1'b0;
    chk("restart", {61'd0, busy, done, valid}, 64'd4);
    chk("restart_counts", 64'(counts), 64'd0);
    run(2'b01, 3, "lat_restart");

    repeat (3) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
